// File: rtl/rect_fill_arbiter.sv
// rect_fill_arbiter
//   Shares the single vga_adapter pixel-write port among N rectangle-draw
//   requesters (snake head, tail eraser, apple). One requester is granted at
//   a time. Its rectangle is raster-filled at one pixel per clock, and pixels
//   that fall outside the XSCREEN x YSCREEN screen are suppressed.
//
//   Ports
//     CLOCK_50    system clock
//     Resetn      synchronous, active-low reset
//     req         req[i]=1: requester i has a rectangle pending
//     req_x/y     packed origin coordinates, slice i = [i*XW +: XW] / [i*YW +: YW]
//     req_w/h     packed rectangle width / height in pixels (0 = empty)
//     req_colour  packed 3-bit fill colour
//     grant       one-hot pulse while requester i's fields are being latched
//     done        one-hot pulse when requester i's fill is complete
//     busy        high whenever the arbiter is not idle
//     VGA_X/Y     pixel coordinate to vga_adapter
//     VGA_COLOR   pixel colour to vga_adapter
//     plot        pixel write strobe to vga_adapter
//
//   Configuration macro RECT_ARB_FIXED_PRIO_EN: when defined, the lowest
//   asserted request index always wins and no round-robin pointer exists.
//   When undefined (default), arbitration is round-robin.
module rect_fill_arbiter #(
    parameter int N       = 3,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int SZW     = 4,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic [N-1:0]     req,
    input  logic [N*XW-1:0]  req_x,
    input  logic [N*YW-1:0]  req_y,
    input  logic [N*SZW-1:0] req_w,
    input  logic [N*SZW-1:0] req_h,
    input  logic [N*3-1:0]   req_colour,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     done,
    output logic             busy,
    output logic [XW-1:0]    VGA_X,
    output logic [YW-1:0]    VGA_Y,
    output logic [2:0]       VGA_COLOR,
    output logic             plot
);

    localparam int             IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
    localparam logic [XW:0]    X_LIM    = (XW + 1)'(XSCREEN);
    localparam logic [YW:0]    Y_LIM    = (YW + 1)'(YSCREEN);
    localparam logic [SZW-1:0] SZ_ONE   = SZW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  win, win_n, pick;
    logic           any_req;
    logic [SZW-1:0] xc, xc_n, yc, yc_n;

    // Captured rectangle (data only, no reset needed)
    logic [XW-1:0]  x_r;
    logic [YW-1:0]  y_r;
    logic [SZW-1:0] w_r, h_r;
    logic [2:0]     col_r;

    // Fields of the currently registered winner
    logic [XW-1:0]  sel_x;
    logic [YW-1:0]  sel_y;
    logic [SZW-1:0] sel_w, sel_h;
    logic [2:0]     sel_col;

    logic [N-1:0]   grant_n, done_n;
    logic           busy_n, plot_n;
    logic [XW-1:0]  vga_x_n;
    logic [YW-1:0]  vga_y_n;
    logic [2:0]     vga_col_n;
    logic [XW:0]    px;
    logic [YW:0]    py;

`ifndef RECT_ARB_FIXED_PRIO_EN
    localparam logic [IW:0] N_EXT = (IW + 1)'(N);
    logic [IW-1:0] rr_ptr, rr_n;
    logic [IW:0]   rr_sum;
`endif

    assign sel_x   = req_x[win*XW +: XW];
    assign sel_y   = req_y[win*YW +: YW];
    assign sel_w   = req_w[win*SZW +: SZW];
    assign sel_h   = req_h[win*SZW +: SZW];
    assign sel_col = req_colour[win*3 +: 3];

    // Coordinates are summed one bit wider so that an off-screen pixel never
    // wraps back onto column/row 0.
    function automatic logic [XW:0] pix_x(input logic [XW-1:0] base,
                                          input logic [SZW-1:0] off);
        return {1'b0, base} + {{(XW + 1 - SZW){1'b0}}, off};
    endfunction

    function automatic logic [YW:0] pix_y(input logic [YW-1:0] base,
                                          input logic [SZW-1:0] off);
        return {1'b0, base} + {{(YW + 1 - SZW){1'b0}}, off};
    endfunction

    function automatic logic on_screen(input logic [XW:0] cx, input logic [YW:0] cy);
        return (cx < X_LIM) && (cy < Y_LIM);
    endfunction

    // Winner selection. The loops run from the far end so the last hit, which
    // is the highest-priority candidate, is the one that sticks.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
`ifdef RECT_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = IW'(i);
                any_req = 1'b1;
            end
        end
`else
        rr_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (rr_sum >= N_EXT) begin
                rr_sum = rr_sum - N_EXT;
            end
            if (req[rr_sum[IW-1:0]]) begin
                pick    = rr_sum[IW-1:0];
                any_req = 1'b1;
            end
        end
`endif
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n   = state;
        win_n     = win;
        xc_n      = xc;
        yc_n      = yc;
        grant_n   = '0;
        done_n    = '0;
        plot_n    = 1'b0;
        vga_x_n   = VGA_X;
        vga_y_n   = VGA_Y;
        vga_col_n = VGA_COLOR;
        px        = '0;
        py        = '0;
`ifndef RECT_ARB_FIXED_PRIO_EN
        rr_n      = rr_ptr;
`endif
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_n       = S_LATCH;
                    win_n         = pick;
                    grant_n[pick] = 1'b1;
                end
            end
            S_LATCH: begin
                xc_n = '0;
                yc_n = '0;
                if (sel_w == '0 || sel_h == '0) begin
                    state_n     = S_DONE;
                    done_n[win] = 1'b1;
                end else begin
                    // First pixel is presented straight from the request fields
                    // so that it appears in the cycle right after the latch.
                    state_n   = S_FILL;
                    px        = pix_x(sel_x, '0);
                    py        = pix_y(sel_y, '0);
                    vga_x_n   = px[XW-1:0];
                    vga_y_n   = py[YW-1:0];
                    vga_col_n = sel_col;
                    plot_n    = on_screen(px, py);
                end
            end
            S_FILL: begin
                if (xc == w_r - SZ_ONE) begin
                    if (yc == h_r - SZ_ONE) begin
                        state_n     = S_DONE;
                        done_n[win] = 1'b1;
                    end else begin
                        xc_n = '0;
                        yc_n = yc + SZ_ONE;
                    end
                end else begin
                    xc_n = xc + SZ_ONE;
                end
                if (state_n == S_FILL) begin
                    px        = pix_x(x_r, xc_n);
                    py        = pix_y(y_r, yc_n);
                    vga_x_n   = px[XW-1:0];
                    vga_y_n   = py[YW-1:0];
                    vga_col_n = col_r;
                    plot_n    = on_screen(px, py);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
`ifndef RECT_ARB_FIXED_PRIO_EN
                rr_n = (win == LAST_IDX) ? '0 : win + IW'(1);
`endif
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            win       <= '0;
            xc        <= '0;
            yc        <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            plot      <= 1'b0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
`ifndef RECT_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state     <= state_n;
            win       <= win_n;
            xc        <= xc_n;
            yc        <= yc_n;
            grant     <= grant_n;
            done      <= done_n;
            busy      <= busy_n;
            plot      <= plot_n;
            VGA_X     <= vga_x_n;
            VGA_Y     <= vga_y_n;
            VGA_COLOR <= vga_col_n;
`ifndef RECT_ARB_FIXED_PRIO_EN
            rr_ptr    <= rr_n;
`endif
        end
    end

    // Request fields are only trusted during LATCH; afterwards the requester
    // may change or drop them freely.
    always_ff @(posedge CLOCK_50) begin
        if (state == S_LATCH) begin
            x_r   <= sel_x;
            y_r   <= sel_y;
            w_r   <= sel_w;
            h_r   <= sel_h;
            col_r <= sel_col;
        end
    end

endmodule

// File: tb/tb_rect_fill_arbiter.sv
// tb_rect_fill_arbiter
//   Directed self-checking bench for rect_fill_arbiter: reset state,
//   a table of single-rectangle fills (clipping, empty rectangles, wide
//   coordinates), round-robin grant order, and reset in the middle of a fill.
module tb_rect_fill_arbiter;

    localparam int N   = 3;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int SZW = 4;

    logic             CLOCK_50 = 1'b0;
    logic             Resetn   = 1'b0;
    logic [N-1:0]     req      = '0;
    logic [N*XW-1:0]  req_x    = '0;
    logic [N*YW-1:0]  req_y    = '0;
    logic [N*SZW-1:0] req_w    = '0;
    logic [N*SZW-1:0] req_h    = '0;
    logic [N*3-1:0]   req_colour = '0;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic             busy;
    logic [XW-1:0]    VGA_X;
    logic [YW-1:0]    VGA_Y;
    logic [2:0]       VGA_COLOR;
    logic             plot;

    rect_fill_arbiter #(
        .N(N), .XW(XW), .YW(YW), .SZW(SZW), .XSCREEN(160), .YSCREEN(120)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_colour(req_colour),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int idx;
        int x;
        int y;
        int w;
        int h;
        int col;
        int exp_plots;
        int exp_done;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_fields(input int idx, input int x, input int y,
                              input int w, input int h, input int col);
        req_x[idx*XW +: XW]        = XW'(x);
        req_y[idx*YW +: YW]        = YW'(y);
        req_w[idx*SZW +: SZW]      = SZW'(w);
        req_h[idx*SZW +: SZW]      = SZW'(h);
        req_colour[idx*3 +: 3]     = 3'(col);
    endtask

    // Issue one request at cycle 0 and follow it until one cycle past done.
    task automatic run_vec(input vec_t v, input int vn);
        int plots;
        int k;
        int ex;
        int ey;
        int eplot;
        plots = 0;
        @(negedge CLOCK_50);
        set_fields(v.idx, v.x, v.y, v.w, v.h, v.col);
        req        = '0;
        req[v.idx] = 1'b1;
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            @(negedge CLOCK_50);
            check($sformatf("v%0d grant c%0d", vn, c), int'(grant),
                  (c == 1) ? (1 << v.idx) : 0);
            check($sformatf("v%0d done c%0d", vn, c), int'(done),
                  (c == v.exp_done) ? (1 << v.idx) : 0);
            check($sformatf("v%0d busy c%0d", vn, c), int'(busy),
                  (c <= v.exp_done) ? 1 : 0);
            if (c >= 2 && c < v.exp_done) begin
                k     = c - 2;
                ex    = v.x + (k % v.w);
                ey    = v.y + (k / v.w);
                eplot = (ex < 160 && ey < 120) ? 1 : 0;
                check($sformatf("v%0d plot c%0d", vn, c), int'(plot), eplot);
                if (eplot == 1) begin
                    check($sformatf("v%0d x c%0d", vn, c), int'(VGA_X), ex);
                    check($sformatf("v%0d y c%0d", vn, c), int'(VGA_Y), ey);
                    check($sformatf("v%0d col c%0d", vn, c), int'(VGA_COLOR), v.col);
                end
            end else begin
                check($sformatf("v%0d plot idle c%0d", vn, c), int'(plot), 0);
            end
            if (plot) plots++;
            // Drop the request and trash its fields once the latch is over.
            if (c == 2) begin
                req        = '0;
                req_x      = ~req_x;
                req_y      = ~req_y;
                req_w      = ~req_w;
                req_h      = ~req_h;
                req_colour = ~req_colour;
            end
        end
        check($sformatf("v%0d plot count", vn), plots, v.exp_plots);
    endtask

    initial begin
        int order[4];
        int exp_order[4];
        int got;
        int seen;

        //            idx  x    y    w   h   col plots done
        vecs[0] = '{0,  10,  20,  3,  2,  2,  6,   8};
        vecs[1] = '{2,  158, 118, 4,  4,  5,  4,   18};
        vecs[2] = '{1,  0,   5,   5,  0,  1,  0,   2};
        vecs[3] = '{0,  7,   9,   0,  5,  4,  0,   2};
        vecs[4] = '{0,  155, 0,   15, 1,  7,  5,   17};
        vecs[5] = '{2,  255, 127, 2,  2,  3,  0,   6};
        vecs[6] = '{1,  0,   119, 1,  3,  6,  1,   5};
        vecs[7] = '{1,  30,  40,  2,  2,  6,  4,   6};
        vecs[8] = '{0,  1,   2,   15, 15, 1,  225, 227};

        // Reset state
        Resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst grant", int'(grant), 0);
        check("rst done", int'(done), 0);
        check("rst busy", int'(busy), 0);
        check("rst plot", int'(plot), 0);
        check("rst vga_x", int'(VGA_X), 0);
        check("rst vga_y", int'(VGA_Y), 0);
        check("rst vga_col", int'(VGA_COLOR), 0);
        Resetn = 1'b1;

        // All three requesters held, 1x1 rectangles: arbitration order
`ifdef RECT_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0};
`endif
        @(negedge CLOCK_50);
        for (int i = 0; i < N; i++) set_fields(i, i * 4, 0, 1, 1, i + 1);
        req = '1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge CLOCK_50);
            if (grant != '0) begin
                order[got] = -1;
                for (int i = 0; i < N; i++) if (grant == N'(1 << i)) order[got] = i;
                got++;
            end
        end
        check("rr grants seen", got, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got) check($sformatf("rr order %0d", i), order[i], exp_order[i]);
        end
        req = '0;
        repeat (8) @(negedge CLOCK_50);
        check("rr idle after", int'(busy), 0);

        // Table of single-rectangle fills
        for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

        // Reset in the middle of a 10x10 fill, request held through reset
        @(negedge CLOCK_50);
        set_fields(0, 0, 0, 10, 10, 3);
        req = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLOCK_50);
            if (c == 1) check("mr grant", int'(grant), 1);
            if (c == 4) begin
                check("mr plot c4", int'(plot), 1);
                check("mr x c4", int'(VGA_X), 2);
            end
        end
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        check("mr rst grant", int'(grant), 0);
        check("mr rst done", int'(done), 0);
        check("mr rst busy", int'(busy), 0);
        check("mr rst plot", int'(plot), 0);
        check("mr rst vga_x", int'(VGA_X), 0);
        check("mr rst vga_y", int'(VGA_Y), 0);
        check("mr rst vga_col", int'(VGA_COLOR), 0);
        Resetn = 1'b1;
        @(negedge CLOCK_50);
        check("mr regrant", int'(grant), 1);
        check("mr regrant done", int'(done), 0);
        @(negedge CLOCK_50);
        req  = '0;
        seen = 0;
        for (int c = 0; c < 120 && seen == 0; c++) begin
            @(negedge CLOCK_50);
            if (done != '0) begin
                seen = 1;
                check("mr done value", int'(done), 1);
                // regrant was cycle 1 of the new fill; done lands at cycle 102
                check("mr done cycle", c + 3, 102);
            end
        end
        check("mr done seen", seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
